sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares the single-port on-chip SRAM (memory subsystem: data/address/ena/wren/readout) between two
//  requesters: port 0 = slc3 CPU bus, port 1 = debug/program loader. Serialises one transaction at a
//  time, latches the winner's command, drives the SRAM for one cycle and returns ack + read data.
//  Sits between slc3/loader and the memory instance in processor_top.
// PARAMETERS
//  ADDR_W        10  SRAM word-address width; mem_addr_o = pN_addr_i[ADDR_W-1:0], upper bits ignored
//  READ_LATENCY  1   SRAM cycles from ena-sampled edge to readout valid (>=1)
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  reset_n       in   1       asynchronous, active-low reset
//  p0_req_i      in   1       port 0 request; held high until p0_ack_o
//  p0_we_i       in   1       port 0 write (1) / read (0)
//  p0_addr_i     in   16      port 0 word address
//  p0_wdata_i    in   16      port 0 write data
//  p0_ack_o      out  1       1-cycle completion pulse
//  p0_rdata_o    out  16      read data, valid with p0_ack_o, held until next p0 read ack
//  p1_*          --   --      identical set for port 1 (req, we, addr, wdata, ack, rdata)
//  mem_addr_o    out  ADDR_W  to memory.address
//  mem_wdata_o   out  16      to memory.data
//  mem_ena_o     out  1       to memory.ena, 1-cycle pulse per transaction
//  mem_wren_o    out  1       to memory.wren, high only with mem_ena_o on writes
//  mem_rdata_i   in   16      from memory.readout
//  busy_o        out  1       1 in any state but IDLE
//  owner_o       out  1       port of current/last transaction
// BEHAVIOUR
//  - Only one clock and one reset domain. Reset (reset_n=0, async): state IDLE; all outputs 0; owner_o=1
//    and rr pointer=1 (so port 0 wins first tie); wait counter 0.
//  - FSM: IDLE -> ISSUE -> [WAIT] -> DONE -> IDLE.
//    IDLE : at edge E0, if any req, pick winner, latch we/addr[ADDR_W-1:0]/wdata, -> ISSUE.
//    ISSUE: mem_ena_o=1, mem_wren_o=we, addr/wdata from latch (all registered, no comb path from pN_*).
//           At E1: write -> DONE; read -> WAIT, counter := 1.
//    WAIT : at each edge, if counter==READ_LATENCY capture mem_rdata_i into winner's rdata reg -> DONE,
//           else counter++. Read: DONE entered at E(1+READ_LATENCY).
//    DONE : winner's ack_o=1 for exactly this cycle; -> IDLE unconditionally.
//  - Latency from req sampled (E0) to ack cycle: write 2 cycles, read 2+READ_LATENCY cycles.
//    Max throughput: one write per 3 cycles; req held through DONE is not re-granted that same edge.
//  - Arbitration (default round-robin): one req -> that port. Both -> port != rr pointer; pointer := winner.
//  - Command latched at grant; later changes of pN_* before ack have no effect. req dropped mid-transaction:
//    transaction completes, ack still pulses, requester ignores it.
//  - Non-owner rdata_o unchanged by other port's transactions; writes never modify rdata_o.
//  - Reset mid-transaction: abandon immediately; a write already driven in ISSUE has taken effect;
//    no ack issued for the abandoned transaction.
//  - No combinational path input->output; mem_* outputs 0 outside ISSUE (addr/wdata may hold latch).
// CONFIGURATION
//  SRAM_ARB_CPU_PRIO_EN defined: fixed priority, port 0 always wins when both request; rr pointer unused
//    (port 1 may starve). Undefined: round-robin as above. Ports, timing otherwise identical.
// TESTING
//  1 p0 write addr 0x0005 data 0xBEEF -> one cycle mem_ena=1,wren=1,addr=0x005,wdata=0xBEEF; p0_ack 2 cycles after E0.
//  2 p0 read 0x0005 (memory model READ_LATENCY=1) -> mem_ena=1,wren=0; p0_ack at E0+3 with p0_rdata=0xBEEF.
//  3 p0,p1 reads held continuously from reset -> grants p0,p1,p0,p1; each ack only on its own port.
//  4 SRAM_ARB_CPU_PRIO_EN, p0 and p1 held continuously -> only p0_ack pulses over 20 transactions; p1 served once p0 drops.
//  5 reset_n low during WAIT of a p1 read -> all outputs 0 same cycle, no p1_ack; after release p1 read completes normally.
//  6 p1 write addr 0x0405 data 0x1234 -> mem_addr_o=0x005; subsequent p0 read 0x0005 returns 0x1234; p0_rdata unchanged by write.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Request/response bundle for one requester of the SRAM arbiter.
//   master : requester side (drives req/we/addr/wdata, receives ack/rdata)
//   slave  : arbiter side
// Signals
//   req    request, held high until ack
//   we     1 = write, 0 = read
//   addr   16-bit word address (arbiter uses the low ADDR_W bits)
//   wdata  16-bit write data
//   ack    1-cycle completion pulse
//   rdata  read data, valid with ack, held until the next read ack of this port
interface sram_arbiter_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;

    modport master (output req, output we, output addr, output wdata,
                    input  ack, input  rdata);
    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output ack, output rdata);
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one single-port SRAM between port 0 (CPU bus) and port 1 (debug /
//   program loader). One transaction at a time: the winner's command is latched
//   at grant, the SRAM is driven for one cycle, then ack (and read data) return.
//
//   Build option: SRAM_ARB_CPU_PRIO_EN
//     defined   -> fixed priority, port 0 wins whenever both request
//     undefined -> round-robin between the two ports
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   p0, p1       requester bundles (sram_arbiter_if.slave)
//   mem_addr_o   SRAM address (low ADDR_W bits of the latched address)
//   mem_wdata_o  SRAM write data
//   mem_ena_o    SRAM enable, one-cycle pulse per transaction
//   mem_wren_o   SRAM write enable, only together with mem_ena_o
//   mem_rdata_i  SRAM read data
//   busy_o       1 whenever the FSM is not idle
//   owner_o      port of the current / last transaction
//
// State table
//   state     | meaning
//   ST_IDLE   | waiting for a request, arbitrate and latch command on grant
//   ST_ISSUE  | SRAM access cycle (ena, and wren for writes)
//   ST_WAIT   | read only: count READ_LATENCY cycles, then capture readout
//   ST_DONE   | ack pulse to the owner, always back to idle
module sram_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    sram_arbiter_if.slave     p0,
    sram_arbiter_if.slave     p1,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_wdata_o,
    output logic              mem_ena_o,
    output logic              mem_wren_o,
    input  logic [15:0]       mem_rdata_i,
    output logic              busy_o,
    output logic              owner_o
);

    localparam int CNT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;   // doubles as the round-robin pointer
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cmd_we_q;
    logic [ADDR_W-1:0]  cmd_addr_q;
    logic [15:0]        cmd_wdata_q;
    logic [15:0]        p0_rdata_q, p1_rdata_q;

    logic               grant_vld;
    logic               grant_port;
    logic               latch_cmd;
    logic               capture;

    // Arbitration
    always_comb begin
        grant_vld = p0.req | p1.req;
`ifdef SRAM_ARB_CPU_PRIO_EN
        grant_port = ~p0.req;
`else
        // On a tie the port that did not win last time goes next.
        grant_port = (p0.req & p1.req) ? ~owner_q : ~p0.req;
`endif
    end

    // Next state
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        latch_cmd = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    latch_cmd = 1'b1;
                    owner_d   = grant_port;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_we_q) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(READ_LATENCY)) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b1;
            cnt_q       <= '0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            if (latch_cmd) begin
                cmd_we_q    <= grant_port ? p1.we : p0.we;
                cmd_addr_q  <= grant_port ? p1.addr[ADDR_W-1:0] : p0.addr[ADDR_W-1:0];
                cmd_wdata_q <= grant_port ? p1.wdata : p0.wdata;
            end
            if (capture) begin
                if (owner_q) begin
                    p1_rdata_q <= mem_rdata_i;
                end else begin
                    p0_rdata_q <= mem_rdata_i;
                end
            end
        end
    end

    // Every output decodes flops only, so no requester input reaches an output
    // in the same cycle.
    assign mem_ena_o   = (state_q == ST_ISSUE);
    assign mem_wren_o  = (state_q == ST_ISSUE) & cmd_we_q;
    assign mem_addr_o  = cmd_addr_q;
    assign mem_wdata_o = cmd_wdata_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign owner_o     = owner_q;

    assign p0.ack   = (state_q == ST_DONE) & ~owner_q;
    assign p1.ack   = (state_q == ST_DONE) &  owner_q;
    assign p0.rdata = p0_rdata_q;
    assign p1.rdata = p1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ena;
    logic        mem_wren;
    logic [15:0] mem_rdata = 16'h0;
    logic        busy;
    logic        owner;

    int total = 0;
    int bad   = 0;

    sram_arbiter_if p0_if ();
    sram_arbiter_if p1_if ();

    sram_arbiter #(.ADDR_W(10), .READ_LATENCY(1)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .p0          (p0_if),
        .p1          (p1_if),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ena_o   (mem_ena),
        .mem_wren_o  (mem_wren),
        .mem_rdata_i (mem_rdata),
        .busy_o      (busy),
        .owner_o     (owner)
    );

    always #5 clk = ~clk;

    // SRAM model, one cycle read latency, contents survive reset
    logic [15:0] mem [0:1023];
    initial for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    always @(posedge clk) begin
        if (mem_ena) begin
            if (mem_wren) mem[mem_addr] <= mem_wdata;
            else          mem_rdata     <= mem[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit port, input logic req, input logic we,
                         input logic [15:0] a, input logic [15:0] d);
        if (port) begin
            p1_if.req = req; p1_if.we = we; p1_if.addr = a; p1_if.wdata = d;
        end else begin
            p0_if.req = req; p0_if.we = we; p0_if.addr = a; p0_if.wdata = d;
        end
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [9:0]  exp_maddr;
        logic [15:0] exp_rdata;   // own port rdata after ack
        int          exp_lat;     // cycles from grant edge to ack cycle
        logic [15:0] exp_other;   // other port rdata after ack
    } vec_t;

    vec_t vecs [9];

    // One isolated transaction; command inputs are scrambled right after the
    // grant edge to show the latched command is what reaches the SRAM.
    task automatic run_vec(input vec_t v);
        int          cyc = 0;
        int          ena_cnt = 0;
        int          other_ack = 0;
        int          stray_wren = 0;
        bit          got = 0;
        logic [9:0]  s_addr = '0;
        logic        s_wren = 1'b0;
        logic [15:0] s_wdata = '0;
        @(negedge clk);
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        while (!got && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) drive(v.port, 1'b1, ~v.we, ~v.addr, ~v.wdata);
            #1;
            if (mem_ena) begin
                ena_cnt++;
                s_addr  = mem_addr;
                s_wren  = mem_wren;
                s_wdata = mem_wdata;
            end else if (mem_wren) begin
                stray_wren++;
            end
            if (v.port ? p0_if.ack : p1_if.ack) other_ack++;
            if (v.port ? p1_if.ack : p0_if.ack) got = 1;
        end
        drive(v.port, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("ack_seen", 32'(got), 32'd1);
        chk("latency", cyc, v.exp_lat);
        chk("ena_pulses", ena_cnt, 32'd1);
        chk("stray_wren", stray_wren, 32'd0);
        chk("mem_addr", 32'(s_addr), 32'(v.exp_maddr));
        chk("mem_wren", 32'(s_wren), 32'(v.we));
        if (v.we) chk("mem_wdata", 32'(s_wdata), 32'(v.wdata));
        chk("own_rdata", 32'(v.port ? p1_if.rdata : p0_if.rdata), 32'(v.exp_rdata));
        chk("other_rdata", 32'(v.port ? p0_if.rdata : p1_if.rdata), 32'(v.exp_other));
        chk("other_ack", other_ack, 32'd0);
        chk("owner", 32'(owner), 32'(v.port));
        @(posedge clk);
        #2;
        chk("ack_width", 32'(v.port ? p1_if.ack : p0_if.ack), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_ena"},   32'(mem_ena), 32'd0);
        chk({tag, "_mem_wren"},  32'(mem_wren), 32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_p0_ack"},    32'(p0_if.ack), 32'd0);
        chk({tag, "_p1_ack"},    32'(p1_if.ack), 32'd0);
        chk({tag, "_p0_rdata"},  32'(p0_if.rdata), 32'd0);
        chk({tag, "_p1_rdata"},  32'(p1_if.rdata), 32'd0);
        chk({tag, "_busy"},      32'(busy), 32'd0);
        chk({tag, "_owner"},     32'(owner), 32'd1);
    endtask

    initial begin
        int   n;
        int   both;
        int   cyc;
        bit   got;
        bit   order [20];

        //            port we addr      wdata    maddr   rdata    lat other
        vecs[0] = '{1'b0, 1'b1, 16'h0005, 16'hBEEF, 10'h005, 16'h0000, 2, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 10'h005, 16'hBEEF, 3, 16'h0000};
        vecs[2] = '{1'b1, 1'b1, 16'h0405, 16'h1234, 10'h005, 16'h0000, 2, 16'hBEEF};
        vecs[3] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 10'h005, 16'h1234, 3, 16'h0000};
        vecs[4] = '{1'b1, 1'b1, 16'h03FF, 16'hA5A5, 10'h3FF, 16'h0000, 2, 16'h1234};
        vecs[5] = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 10'h3FF, 16'hA5A5, 3, 16'h1234};
        vecs[6] = '{1'b0, 1'b1, 16'hFC00, 16'h5555, 10'h000, 16'h1234, 2, 16'hA5A5};
        vecs[7] = '{1'b1, 1'b0, 16'h0400, 16'h0000, 10'h000, 16'h5555, 3, 16'h1234};
        vecs[8] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 10'h000, 16'h5555, 3, 16'h5555};

        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Both ports hold reads from reset: round-robin alternates starting
        // with port 0; fixed priority serves port 0 only.
        @(negedge clk);
        reset_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0);
        drive(1'b1, 1'b1, 1'b0, 16'h0400, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0; both = 0; cyc = 0;
        while (n < 20 && cyc < 200) begin
            @(posedge clk);
            #2;
            cyc++;
            if (p0_if.ack && p1_if.ack) both++;
            if (p0_if.ack || p1_if.ack) begin
                order[n] = p1_if.ack;
                n++;
            end
        end
        chk("contend_acks", n, 32'd20);
        chk("contend_both_ack", both, 32'd0);
        for (int i = 0; i < 20; i++) begin
`ifdef SRAM_ARB_CPU_PRIO_EN
            chk("contend_order", 32'(order[i]), 32'd0);
`else
            chk("contend_order", 32'(order[i]), 32'(i % 2));
`endif
        end
        chk("contend_p0_rdata", 32'(p0_if.rdata), 32'h1234);
`ifndef SRAM_ARB_CPU_PRIO_EN
        chk("contend_p1_rdata", 32'(p1_if.rdata), 32'h5555);
`endif
        // Port 0 drops; port 1 must now be served.
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        got = 0; both = 0; cyc = 0;
        while (!got && cyc < 20) begin
            @(posedge clk);
            #2;
            cyc++;
            if (p0_if.ack) both++;
            if (p1_if.ack) got = 1;
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("p1_served", 32'(got), 32'd1);
        chk("p0_no_ack_after_drop", both, 32'd0);
        chk("p1_served_rdata", 32'(p1_if.rdata), 32'h5555);
        repeat (2) @(posedge clk);

        // Reset while a port 1 read sits in WAIT.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 16'h03FF, 16'h0);
        @(posedge clk);
        #2;
        chk("rst_seq_issue_ena", 32'(mem_ena), 32'd1);
        @(posedge clk);
        #2;
        chk("rst_seq_wait_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        both = 0;
        repeat (2) begin
            @(posedge clk);
            #2;
            if (p1_if.ack) both++;
        end
        chk("midrst_no_ack", both, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        got = 0; cyc = 0;
        while (!got && cyc < 12) begin
            @(posedge clk);
            #2;
            cyc++;
            if (p1_if.ack) got = 1;
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("postrst_ack", 32'(got), 32'd1);
        chk("postrst_latency", cyc, 32'd3);
        chk("postrst_rdata", 32'(p1_if.rdata), 32'hA5A5);
        chk("postrst_p0_rdata", 32'(p0_if.rdata), 32'h0000);
        chk("postrst_owner", 32'(owner), 32'd1);
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
